// File: rtl/sw_pkg.sv
// Shared definitions for the switch-core stream blocks.
//   arb_state_t  : two-state frame arbiter FSM encoding
//   clog2_min1() : index width helper that never returns 0
//   SW_*         : default stream geometry shared by the switch blocks
package sw_pkg;

    localparam int SW_PORTS       = 4;
    localparam int SW_DATA_W      = 64;
    localparam int SW_CNT_W       = 32;
    localparam int SW_STALL_LIMIT = 1024;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_PASS = 1'b1
    } arb_state_t;

    // Width of an index into n items; at least 1 bit so single-item
    // vectors still produce a legal declaration.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_axis_frame_arbiter_if.sv
// Stream bundle for the frame arbiter: N ingress AXI-Stream ports plus one
// egress port with a tdest source index.
//   slave  : arbiter view (consumes ingress, produces egress)
//   master : environment view (produces ingress, consumes egress)
interface sw_axis_frame_arbiter_if
    import sw_pkg::*;
#(
    parameter int N      = SW_PORTS,
    parameter int DATA_W = SW_DATA_W
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int IDX_W  = clog2_min1(N);

    logic [N-1:0][DATA_W-1:0] s_axis_tdata;
    logic [N-1:0][KEEP_W-1:0] s_axis_tkeep;
    logic [N-1:0]             s_axis_tlast;
    logic [N-1:0]             s_axis_tvalid;
    logic [N-1:0]             s_axis_tready;

    logic [DATA_W-1:0]        m_axis_tdata;
    logic [KEEP_W-1:0]        m_axis_tkeep;
    logic                     m_axis_tlast;
    logic                     m_axis_tvalid;
    logic                     m_axis_tready;
    logic [IDX_W-1:0]         m_axis_tdest;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid, m_axis_tdest,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid, m_axis_tdest,
        output m_axis_tready
    );

endinterface

// File: rtl/sw_rr_prio_sel.sv
// Combinational round-robin priority encoder.
//   req  : request vector
//   last : index granted last time; search starts at last+1 and wraps
//   sel  : first requesting index found (0 when none)
//   any  : at least one request is set
module sw_rr_prio_sel
    import sw_pkg::*;
#(
    parameter int N = SW_PORTS
) (
    input  logic [N-1:0]               req,
    input  logic [clog2_min1(N)-1:0]   last,
    output logic [clog2_min1(N)-1:0]   sel,
    output logic                       any
);
    localparam int IDX_W = clog2_min1(N);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no
        // path through the block can leave a latch behind.
        sel  = '0;
        any  = 1'b0;
        cand = '0;
        // k = N revisits 'last' itself, so a lone requester keeps winning.
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(last) + k) % N);
            if (!any && req[cand]) begin
                any = 1'b1;
                sel = cand;
            end
        end
    end

endmodule

// File: rtl/sw_axis_frame_arbiter.sv
// Frame-aware round-robin arbiter: merges N ingress streams onto one egress
// stream, holding the grant from first beat to tlast so frames never
// interleave. Keeps per-port completed-frame counters and a sticky
// source-stall flag per port.
//   clk, rst         : clock, synchronous active-high reset
//   axis             : ingress/egress stream bundle (slave view)
//   cfg_port_en      : per-port arbitration enable
//   stall_clr        : per-port 1-cycle clear of status_stall
//   status_busy      : a frame is in progress
//   status_grant     : current or last granted port
//   status_frame_cnt : completed frames per port (wrapping)
//   status_stall     : sticky per-port stall flags
// The interface must be instantiated with the same N and DATA_W.
module sw_axis_frame_arbiter
    import sw_pkg::*;
#(
    parameter int N           = SW_PORTS,
    parameter int DATA_W      = SW_DATA_W,
    parameter int CNT_W       = SW_CNT_W,
    parameter int STALL_LIMIT = SW_STALL_LIMIT
) (
    input  logic                          clk,
    input  logic                          rst,
    sw_axis_frame_arbiter_if.slave        axis,
    input  logic [N-1:0]                  cfg_port_en,
    input  logic [N-1:0]                  stall_clr,
    output logic                          status_busy,
    output logic [clog2_min1(N)-1:0]      status_grant,
    output logic [N-1:0][CNT_W-1:0]       status_frame_cnt,
    output logic [N-1:0]                  status_stall
);
    localparam int IDX_W   = clog2_min1(N);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
    localparam logic [STALL_W-1:0] STALL_PRE = STALL_W'(STALL_LIMIT - 1);

    arb_state_t               state, next_state;
    logic [IDX_W-1:0]         grant, last_grant, rr_sel;
    logic                     rr_any;
    logic [N-1:0]             req;
    logic [STALL_W-1:0]       stall_cnt;
    logic [N-1:0][CNT_W-1:0]  frame_cnt;
    logic [N-1:0]             stall_flag;
    logic                     in_pass, src_valid, beat_fire, frame_done;
    logic                     stall_tick, stall_hit;

    assign req = axis.s_axis_tvalid & cfg_port_en;

    sw_rr_prio_sel #(.N(N)) u_rr_sel (
        .req  (req),
        .last (last_grant),
        .sel  (rr_sel),
        .any  (rr_any)
    );

    assign in_pass    = (state == ARB_PASS);
    assign src_valid  = axis.s_axis_tvalid[grant];
    assign beat_fire  = in_pass & src_valid & axis.m_axis_tready;
    assign frame_done = beat_fire & axis.s_axis_tlast[grant];
    // Only a missing source beat counts; egress back-pressure freezes the count.
    assign stall_tick = in_pass & ~src_valid & axis.m_axis_tready;
    assign stall_hit  = stall_tick & (stall_cnt == STALL_PRE);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: flops use <= so every register samples pre-edge values;
        // combinational blocks use = so later statements see earlier ones.
        if (rst) state <= ARB_IDLE;
        else     state <= next_state;
    end

    // Next-state logic: grant is released only by a transferred tlast.
    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: if (rr_any)     next_state = ARB_PASS;
            ARB_PASS: if (frame_done) next_state = ARB_IDLE;
            default:                  next_state = ARB_IDLE;
        endcase
    end

    // Output logic: combinational pass-through of the granted port.
    always_comb begin
        axis.s_axis_tready = '0;
        axis.m_axis_tdata  = '0;
        axis.m_axis_tkeep  = '0;
        axis.m_axis_tlast  = 1'b0;
        axis.m_axis_tvalid = 1'b0;
        axis.m_axis_tdest  = '0;
        if (in_pass) begin
            axis.m_axis_tdata         = axis.s_axis_tdata[grant];
            axis.m_axis_tkeep         = axis.s_axis_tkeep[grant];
            axis.m_axis_tlast         = axis.s_axis_tlast[grant];
            axis.m_axis_tvalid        = src_valid;
            axis.m_axis_tdest         = grant;
            axis.s_axis_tready[grant] = axis.m_axis_tready;
        end
    end

    // Grant bookkeeping, frame counters and stall watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= '0;
            last_grant <= IDX_W'(N - 1);
            stall_cnt  <= '0;
            // NOTE: the counter array is a handful of flops read by software,
            // so it is reset like any other register rather than left at power-up.
            frame_cnt  <= '0;
            stall_flag <= '0;
        end else begin
            if (state == ARB_IDLE && rr_any) begin
                grant     <= rr_sel;
                stall_cnt <= '0;
            end

            if (frame_done) begin
                frame_cnt[grant] <= frame_cnt[grant] + CNT_W'(1);
                last_grant       <= grant;
            end

            if (beat_fire) begin
                stall_cnt <= '0;
            end else if (stall_tick && stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end

            // Set is applied after clear so a same-cycle set wins.
            stall_flag <= (stall_flag & ~stall_clr) | (stall_hit ? (N'(1) << grant) : '0);
        end
    end

    assign status_busy      = in_pass;
    assign status_grant     = grant;
    assign status_frame_cnt = frame_cnt;
    assign status_stall     = stall_flag;

endmodule

// File: tb/tb_sw_axis_frame_arbiter.sv
// Self-checking bench for sw_axis_frame_arbiter (N=4, STALL_LIMIT=8).
// Sources are modelled per port (frame length, frames left, beat index);
// each cycle: apply() drives inputs, outputs are compared, advance()
// records handshakes and steps one clock.
module tb_sw_axis_frame_arbiter;
    import sw_pkg::*;

    localparam int N           = 4;
    localparam int DATA_W      = 64;
    localparam int CNT_W       = 8;
    localparam int STALL_LIMIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]            cfg_port_en;
    logic [N-1:0]            stall_clr;
    logic                    status_busy;
    logic [1:0]              status_grant;
    logic [N-1:0][CNT_W-1:0] status_frame_cnt;
    logic [N-1:0]            status_stall;

    sw_axis_frame_arbiter_if #(.N(N), .DATA_W(DATA_W)) axis ();

    sw_axis_frame_arbiter #(
        .N(N), .DATA_W(DATA_W), .CNT_W(CNT_W), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .axis             (axis),
        .cfg_port_en      (cfg_port_en),
        .stall_clr        (stall_clr),
        .status_busy      (status_busy),
        .status_grant     (status_grant),
        .status_frame_cnt (status_frame_cnt),
        .status_stall     (status_stall)
    );

    // Source model state
    int         src_len   [N];
    int         src_left  [N];
    int         src_beat  [N];
    int         src_frame [N];
    bit         src_hold  [N];
    logic       m_rdy;
    logic [N-1:0] cfg;

    typedef struct {
        int          dest;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;
    beat_t egress [$];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic         m_rdy;
        logic [N-1:0] cfg;
        logic         exp_valid;
        int           exp_dest;
        logic         exp_last;
        logic [N-1:0] exp_sready;
        logic         exp_busy;
    } vec_t;

    function automatic vec_t v_idle();
        return '{1'b1, 4'hF, 1'b0, 0, 1'b0, 4'h0, 1'b0};
    endfunction

    function automatic vec_t v_beat(input int p, input logic l);
        return '{1'b1, 4'hF, 1'b1, p, l, N'(1 << p), 1'b1};
    endfunction

    function automatic logic [63:0] pat(input int p, input int f, input int b);
        return {8'h5A, 8'(p), 16'(f), 32'(b)};
    endfunction

    function automatic logic [7:0] kpat(input int b);
        return 8'(8'hFF >> (b % 8));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < N; i++) begin
            src_len[i]   = 1;
            src_left[i]  = 0;
            src_beat[i]  = 0;
            src_frame[i] = 0;
            src_hold[i]  = 1'b0;
        end
        egress.delete();
        stall_clr = '0;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            axis.s_axis_tvalid[i] = (src_left[i] > 0) && !src_hold[i];
            axis.s_axis_tlast[i]  = (src_beat[i] == src_len[i] - 1);
            axis.s_axis_tdata[i]  = pat(i, src_frame[i], src_beat[i]);
            axis.s_axis_tkeep[i]  = kpat(src_beat[i]);
        end
        axis.m_axis_tready = m_rdy;
        cfg_port_en        = cfg;
        #1;
    endtask

    task automatic advance();
        bit    fired [N];
        beat_t b;
        for (int i = 0; i < N; i++)
            fired[i] = (axis.s_axis_tvalid[i] === 1'b1) && (axis.s_axis_tready[i] === 1'b1);
        if (axis.m_axis_tvalid === 1'b1 && axis.m_axis_tready === 1'b1) begin
            b.dest = int'(axis.m_axis_tdest);
            b.data = axis.m_axis_tdata;
            b.keep = axis.m_axis_tkeep;
            b.last = axis.m_axis_tlast;
            egress.push_back(b);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fired[i]) begin
                src_beat[i]++;
                if (src_beat[i] == src_len[i]) begin
                    src_beat[i] = 0;
                    src_frame[i]++;
                    src_left[i]--;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset_model();
        rst   = 1'b1;
        m_rdy = 1'b1;
        cfg   = '1;
        apply();
        advance();
        rst = 1'b0;
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs [21];
        int   first_cyc;
        int   bad_ready;
        int   n_dest2;
        int   order [$];
        int   exp_order [5];
        bit   found;

        // ---------------- reset state, with a source already requesting ----
        reset_model();
        m_rdy = 1'b1;
        cfg   = '1;
        src_len[3]  = 2;
        src_left[3] = 1;
        rst = 1'b1;
        apply(); advance();
        apply(); advance();
        apply();
        check("rst m_tvalid", 64'(axis.m_axis_tvalid), 64'(0));
        check("rst s_tready", 64'(axis.s_axis_tready), 64'(0));
        check("rst m_tdata",  axis.m_axis_tdata,       64'(0));
        check("rst m_tkeep",  64'(axis.m_axis_tkeep),  64'(0));
        check("rst m_tlast",  64'(axis.m_axis_tlast),  64'(0));
        check("rst m_tdest",  64'(axis.m_axis_tdest),  64'(0));
        check("rst busy",     64'(status_busy),        64'(0));
        check("rst grant",    64'(status_grant),       64'(0));
        check("rst frame_cnt", 64'(status_frame_cnt),  64'(0));
        check("rst stall",    64'(status_stall),       64'(0));

        // ---------------- round robin, table driven -------------------------
        vecs = '{v_idle(),
                 v_beat(0, 1'b0), v_beat(0, 1'b0), v_beat(0, 1'b1), v_idle(),
                 v_beat(1, 1'b0), v_beat(1, 1'b0), v_beat(1, 1'b1), v_idle(),
                 v_beat(2, 1'b0), v_beat(2, 1'b0), v_beat(2, 1'b1), v_idle(),
                 v_beat(3, 1'b0), v_beat(3, 1'b0), v_beat(3, 1'b1), v_idle(),
                 v_beat(0, 1'b0), v_beat(0, 1'b0), v_beat(0, 1'b1), v_idle()};
        do_reset();
        for (int i = 0; i < N; i++) begin
            src_len[i]  = 3;
            src_left[i] = 2;
        end
        for (int c = 0; c < 21; c++) begin
            m_rdy = vecs[c].m_rdy;
            cfg   = vecs[c].cfg;
            apply();
            check($sformatf("rr c%0d tvalid", c), 64'(axis.m_axis_tvalid), 64'(vecs[c].exp_valid));
            check($sformatf("rr c%0d s_tready", c), 64'(axis.s_axis_tready), 64'(vecs[c].exp_sready));
            check($sformatf("rr c%0d busy", c), 64'(status_busy), 64'(vecs[c].exp_busy));
            if (vecs[c].exp_valid) begin
                check($sformatf("rr c%0d tdest", c), 64'(axis.m_axis_tdest), 64'(vecs[c].exp_dest));
                check($sformatf("rr c%0d tlast", c), 64'(axis.m_axis_tlast), 64'(vecs[c].exp_last));
            end
            advance();
        end
        apply();
        check("rr frame_cnt0", 64'(status_frame_cnt[0]), 64'(2));
        check("rr frame_cnt1", 64'(status_frame_cnt[1]), 64'(1));
        check("rr frame_cnt2", 64'(status_frame_cnt[2]), 64'(1));
        check("rr frame_cnt3", 64'(status_frame_cnt[3]), 64'(1));
        check("rr next grant", 64'(status_grant), 64'(1));

        // ---------------- single source, 5-beat frame on port 2 -------------
        do_reset();
        src_len[2]  = 5;
        src_left[2] = 1;
        first_cyc   = -1;
        bad_ready   = 0;
        for (int c = 0; c < 8; c++) begin
            apply();
            if ((axis.s_axis_tready & 4'b1011) != 4'b0000) bad_ready++;
            if (axis.m_axis_tvalid === 1'b1 && first_cyc < 0) first_cyc = c;
            advance();
        end
        check("single other readies", 64'(bad_ready), 64'(0));
        check("single first beat cycle", 64'(first_cyc), 64'(1));
        check("single beat count", 64'(egress.size()), 64'(5));
        for (int b = 0; b < 5 && b < egress.size(); b++) begin
            check($sformatf("single b%0d tdest", b), 64'(egress[b].dest), 64'(2));
            check($sformatf("single b%0d tdata", b), egress[b].data, pat(2, 0, b));
            check($sformatf("single b%0d tkeep", b), 64'(egress[b].keep), 64'(kpat(b)));
            check($sformatf("single b%0d tlast", b), 64'(egress[b].last), 64'(b == 4));
        end
        apply();
        check("single frame_cnt2", 64'(status_frame_cnt[2]), 64'(1));
        check("single frame_cnt0", 64'(status_frame_cnt[0]), 64'(0));

        // ---------------- egress back-pressure, port 1 -----------------------
        do_reset();
        src_len[1]  = 4;
        src_left[1] = 1;
        for (int c = 0; c < 12; c++) begin
            m_rdy = (c % 2 == 0);
            apply();
            if (c == 1) begin
                check("bp tvalid while not ready", 64'(axis.m_axis_tvalid), 64'(1));
                check("bp s_tready while not ready", 64'(axis.s_axis_tready), 64'(0));
            end
            advance();
        end
        m_rdy = 1'b1;
        apply();
        check("bp beat count", 64'(egress.size()), 64'(4));
        for (int b = 0; b < 4 && b < egress.size(); b++) begin
            check($sformatf("bp b%0d tdata", b), egress[b].data, pat(1, 0, b));
            check($sformatf("bp b%0d tlast", b), 64'(egress[b].last), 64'(b == 3));
        end
        check("bp frame_cnt1", 64'(status_frame_cnt[1]), 64'(1));
        check("bp stall", 64'(status_stall), 64'(0));

        // ---------------- port disable, port 1 disabled mid-frame -----------
        do_reset();
        for (int i = 0; i < N; i++) begin
            src_len[i]  = 2;
            src_left[i] = 2;
        end
        cfg = 4'b1011;
        for (int c = 0; c < 25; c++) begin
            if (src_frame[1] == 0 && src_beat[1] == 1) cfg = 4'b1001;
            apply();
            advance();
        end
        exp_order = '{0, 1, 3, 0, 3};
        n_dest2   = 0;
        foreach (egress[k]) begin
            if (egress[k].last) order.push_back(egress[k].dest);
            if (egress[k].dest == 2) n_dest2++;
        end
        check("dis frame count", 64'(order.size()), 64'(5));
        for (int k = 0; k < 5 && k < order.size(); k++)
            check($sformatf("dis frame%0d port", k), 64'(order[k]), 64'(exp_order[k]));
        check("dis port2 beats", 64'(n_dest2), 64'(0));
        apply();
        check("dis frame_cnt0", 64'(status_frame_cnt[0]), 64'(2));
        check("dis frame_cnt1", 64'(status_frame_cnt[1]), 64'(1));
        check("dis frame_cnt2", 64'(status_frame_cnt[2]), 64'(0));
        check("dis frame_cnt3", 64'(status_frame_cnt[3]), 64'(2));

        // ---------------- stall watchdog on port 3 --------------------------
        do_reset();
        src_len[3]  = 4;
        src_left[3] = 1;
        apply(); advance();          // arbitration cycle
        apply(); advance();          // beat 0
        apply(); advance();          // beat 1
        for (int k = 1; k <= 10; k++) begin
            src_hold[3] = 1'b1;
            apply();
            check($sformatf("stall idle%0d flags", k), 64'(status_stall),
                  (k >= 9) ? 64'h8 : 64'h0);
            if (k == 5) check("stall busy while idle", 64'(status_busy), 64'(1));
            advance();
        end
        src_hold[3] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            apply();
            advance();
        end
        apply();
        check("stall frame_cnt3", 64'(status_frame_cnt[3]), 64'(1));
        check("stall beats", 64'(egress.size()), 64'(4));
        check("stall sticky after frame", 64'(status_stall), 64'h8);
        advance();
        stall_clr = 4'b1000;
        apply();
        advance();
        stall_clr = 4'b0000;
        apply();
        check("stall cleared", 64'(status_stall), 64'(0));

        // ---------------- reset mid-frame -----------------------------------
        do_reset();
        src_len[1]  = 1;
        src_left[1] = 1;
        src_len[3]  = 6;
        src_left[3] = 1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            apply();
            if (axis.m_axis_tvalid === 1'b1 && axis.m_axis_tdest == 2'd3 && src_beat[3] == 2)
                found = 1'b1;
            else
                advance();
        end
        check("rmid reached beat 2", 64'(found), 64'(1));
        check("rmid frame_cnt1 before", 64'(status_frame_cnt[1]), 64'(1));
        rst = 1'b1;
        apply();
        advance();
        apply();
        check("rmid tvalid", 64'(axis.m_axis_tvalid), 64'(0));
        check("rmid s_tready", 64'(axis.s_axis_tready), 64'(0));
        check("rmid frame_cnt", 64'(status_frame_cnt), 64'(0));
        check("rmid busy", 64'(status_busy), 64'(0));
        check("rmid grant", 64'(status_grant), 64'(0));
        src_len[0]  = 2;
        src_left[0] = 1;
        rst = 1'b0;
        apply();
        advance();
        apply();
        check("rmid first tvalid", 64'(axis.m_axis_tvalid), 64'(1));
        check("rmid first tdest", 64'(axis.m_axis_tdest), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
